// File: rtl/pipe_ctrl_sequencer_pkg.sv
// Shared types for the pipeline control sequencer: forward selects,
// result-source encodings and the per-stage control bundle.
package rv_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  // Register addresses travel beside this bundle so REG_AW stays a module parameter
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_control;
  } ctrl_stage_t;

  localparam ctrl_stage_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_sequencer_stage_reg.sv
// One pipeline control stage register; reset and flush both load a bubble.
module ctrl_stage_reg
  import rv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  ctrl_stage_t       ctrl_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  output ctrl_stage_t       ctrl_q,
  output logic [REG_AW-1:0] rs1_q,
  output logic [REG_AW-1:0] rs2_q,
  output logic [REG_AW-1:0] rd_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_BUBBLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (flush) begin
      ctrl_q <= CTRL_BUBBLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Carries decoded controls through E/M/W, resolves load-use and branch
// hazards, selects operand forwarding and counts stall/flush events.
module pipe_ctrl_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              ALUSrcD,
  input  logic              MemWriteD,
  input  logic              ResultSrcD,
  input  logic              BranchD,
  input  logic [2:0]        ALUControlD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              ZeroE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              PCSrcE,
  output logic              MemWriteM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [REG_AW-1:0] RdW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int N_STAGE = 3;  // index 0 = E, 1 = M, 2 = W

  ctrl_stage_t       ctrl_dec;
  ctrl_stage_t       ctrl_d [N_STAGE];
  ctrl_stage_t       ctrl_q [N_STAGE];
  logic [REG_AW-1:0] rs1_d  [N_STAGE];
  logic [REG_AW-1:0] rs2_d  [N_STAGE];
  logic [REG_AW-1:0] rd_d   [N_STAGE];
  logic [REG_AW-1:0] rs1_q  [N_STAGE];
  logic [REG_AW-1:0] rs2_q  [N_STAGE];
  logic [REG_AW-1:0] rd_q   [N_STAGE];
  logic              lw_stall;

  // An invalid decode slot enters E as a bubble
  always_comb begin
    ctrl_dec = CTRL_BUBBLE;
    if (ValidD) begin
      ctrl_dec.valid       = 1'b1;
      ctrl_dec.reg_write   = RegWriteD;
      ctrl_dec.alu_src     = ALUSrcD;
      ctrl_dec.mem_write   = MemWriteD;
      ctrl_dec.result_src  = ResultSrcD;
      ctrl_dec.branch      = BranchD;
      ctrl_dec.alu_control = ALUControlD;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_STAGE; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign ctrl_d[gi] = ctrl_dec;
        assign rs1_d[gi]  = ValidD ? Rs1D : '0;
        assign rs2_d[gi]  = ValidD ? Rs2D : '0;
        assign rd_d[gi]   = ValidD ? RdD  : '0;
      end else begin : g_chain
        assign ctrl_d[gi] = ctrl_q[gi-1];
        assign rs1_d[gi]  = rs1_q[gi-1];
        assign rs2_d[gi]  = rs2_q[gi-1];
        assign rd_d[gi]   = rd_q[gi-1];
      end

      ctrl_stage_reg #(.REG_AW(REG_AW)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  ((gi == 0) ? FlushE : 1'b0),
        .ctrl_d (ctrl_d[gi]),
        .rs1_d  (rs1_d[gi]),
        .rs2_d  (rs2_d[gi]),
        .rd_d   (rd_d[gi]),
        .ctrl_q (ctrl_q[gi]),
        .rs1_q  (rs1_q[gi]),
        .rs2_q  (rs2_q[gi]),
        .rd_q   (rd_q[gi])
      );
    end
  endgenerate

  // M wins over W so the youngest producer is forwarded
  function automatic fwd_sel_e fwd_select(
    input logic [REG_AW-1:0] rs,
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] rd_w
  );
    if (rw_m && (rd_m != '0) && (rd_m == rs))
      return FWD_M;
    else if (rw_w && (rd_w != '0) && (rd_w == rs))
      return FWD_W;
    return FWD_RF;
  endfunction

  assign ForwardAE = fwd_select(rs1_q[0], ctrl_q[1].reg_write, rd_q[1],
                                ctrl_q[2].reg_write, rd_q[2]);
  assign ForwardBE = fwd_select(rs2_q[0], ctrl_q[1].reg_write, rd_q[1],
                                ctrl_q[2].reg_write, rd_q[2]);

  assign PCSrcE   = ctrl_q[0].valid & ctrl_q[0].branch & ZeroE;
  assign lw_stall = ctrl_q[0].valid & (ctrl_q[0].result_src == RES_MEM) &
                    ctrl_q[0].reg_write & (rd_q[0] != '0) &
                    ((rd_q[0] == Rs1D) | (rd_q[0] == Rs2D)) & ValidD;

  // A taken branch discards the stalled instruction, so it suppresses the stall
  assign StallF = lw_stall & ~PCSrcE;
  assign StallD = lw_stall & ~PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = lw_stall | PCSrcE;

  assign ALUSrcE     = ctrl_q[0].alu_src;
  assign ALUControlE = ctrl_q[0].alu_control;
  assign MemWriteM   = ctrl_q[1].mem_write;
  assign RegWriteW   = ctrl_q[2].reg_write;
  assign ResultSrcW  = ctrl_q[2].result_src;
  assign RdW         = rd_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (PCSrcE && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // W-stage fields that nothing downstream consumes
  logic unused_w;
  assign unused_w = ^{ctrl_q[2].valid, ctrl_q[2].alu_src, ctrl_q[2].mem_write,
                      ctrl_q[2].branch, ctrl_q[2].alu_control,
                      rs1_q[2], rs2_q[2]};

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Directed bench for pipe_ctrl_sequencer: forwarding, load-use, branch
// flush, x0 handling, reset mid-stall and counter saturation.
module tb_pipe_ctrl_sequencer;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
  logic [2:0]        ALUControlD;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic              ZeroE;
  logic              ALUSrcE;
  logic [2:0]        ALUControlE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              PCSrcE, MemWriteM, RegWriteW, ResultSrcW;
  logic [REG_AW-1:0] RdW;
  logic              StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_sequencer #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .RegWriteD(RegWriteD),
    .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .BranchD(BranchD), .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .ZeroE(ZeroE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcE(PCSrcE),
    .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // valid, regwrite, alusrc, memwrite, resultsrc, branch, aluctl, rs1, rs2, rd
  task automatic set_d(input logic v, input logic rw, input logic as, input logic mw,
                       input logic rs, input logic br, input logic [2:0] ac,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    ValidD = v; RegWriteD = rw; ALUSrcD = as; MemWriteD = mw; ResultSrcD = rs;
    BranchD = br; ALUControlD = ac; Rs1D = r1; Rs2D = r2; RdD = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    set_d(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    ZeroE = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ZeroE = 1'b0;
    set_d(1, 1, 1, 1, 1, 1, 3'd7, 5'd6, 5'd6, 5'd6);
    repeat (3) @(posedge clk);
    #1;
    check("rst_all_outputs",
          {ALUSrcE, ALUControlE, ForwardAE, ForwardBE, PCSrcE, MemWriteM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    rst_n = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check("rel_stall_cnt", stall_cnt, 0);
    check("rel_flush_cnt", flush_cnt, 0);

    // addi x5 ; sub x7,x5,x3 -> forward from M
    set_d(1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd5);
    tick();
    check("addi_alusrc_e", ALUSrcE, 1);
    set_d(1, 1, 0, 0, 0, 0, 3'd1, 5'd5, 5'd3, 5'd7);
    tick();
    check("fwd_m_a", ForwardAE, 2'b10);
    check("fwd_m_b_none", ForwardBE, 2'b00);
    check("sub_aluctl_e", ALUControlE, 3'd1);
    set_d(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check("addi_regwrite_w", RegWriteW, 1);
    check("addi_rd_w", RdW, 5);
    check("addi_ressrc_w", ResultSrcW, 0);
    drain();

    // addi x5 ; nop ; and x8,x5,x5 -> forward from W on both operands
    set_d(1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd5);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    set_d(1, 1, 0, 0, 0, 0, 3'd2, 5'd5, 5'd5, 5'd8);
    tick();
    check("fwd_w_a", ForwardAE, 2'b01);
    check("fwd_w_b", ForwardBE, 2'b01);
    drain();

    // two writers of x5 back to back -> M has priority
    set_d(1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd5);
    tick();
    set_d(1, 1, 1, 0, 0, 0, 3'd0, 5'd2, 5'd0, 5'd5);
    tick();
    set_d(1, 1, 0, 0, 0, 0, 3'd3, 5'd5, 5'd9, 5'd11);
    tick();
    check("fwd_prio_a", ForwardAE, 2'b10);
    check("fwd_prio_b", ForwardBE, 2'b00);
    drain();

    // lw x6 ; add x9,x1,x6 -> one stall, bubble, then W forward
    set_d(1, 1, 1, 0, 1, 0, 3'd0, 5'd1, 5'd0, 5'd6);
    tick();
    set_d(1, 1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd6, 5'd9);
    settle();
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_flushd", FlushD, 0);
    tick();
    check("lu_bubble_alusrc", ALUSrcE, 0);
    check("lu_no_second_stall", StallD, 0);
    check("lu_no_second_flushe", FlushE, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    tick();
    check("lu_fwd_b", ForwardBE, 2'b01);
    check("lu_fwd_a", ForwardAE, 2'b00);
    check("lu_ressrc_w", ResultSrcW, 1);
    check("lu_rd_w", RdW, 6);
    drain();

    // beq taken
    set_d(1, 0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd2, 5'd0);
    tick();
    ZeroE = 1'b1;
    set_d(1, 1, 0, 0, 0, 0, 3'd2, 5'd3, 5'd4, 5'd10);
    settle();
    check("br_pcsrc", PCSrcE, 1);
    check("br_flushd", FlushD, 1);
    check("br_flushe", FlushE, 1);
    check("br_stalld", StallD, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    settle();
    check("br_bubble_aluctl", ALUControlE, 3'd0);
    check("br_bubble_pcsrc", PCSrcE, 0);
    check("br_flush_cnt", flush_cnt, 1);
    ZeroE = 1'b0;
    drain();

    // beq not taken
    set_d(1, 0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd2, 5'd0);
    tick();
    set_d(1, 1, 0, 0, 0, 0, 3'd2, 5'd3, 5'd4, 5'd10);
    settle();
    check("nt_pcsrc", PCSrcE, 0);
    check("nt_flushd", FlushD, 0);
    check("nt_flushe", FlushE, 0);
    tick();
    check("nt_aluctl_kept", ALUControlE, 3'd2);
    check("nt_flush_cnt", flush_cnt, 1);
    drain();

    // load-use and taken branch in the same cycle
    set_d(1, 1, 1, 0, 1, 1, 3'd0, 5'd1, 5'd0, 5'd6);
    tick();
    ZeroE = 1'b1;
    set_d(1, 1, 0, 0, 0, 0, 3'd0, 5'd6, 5'd2, 5'd9);
    settle();
    check("both_stalld", StallD, 0);
    check("both_stallf", StallF, 0);
    check("both_flushd", FlushD, 1);
    check("both_flushe", FlushE, 1);
    tick();
    check("both_stall_cnt", stall_cnt, 1);
    check("both_flush_cnt", flush_cnt, 2);
    drain();

    // writes to x0 never forward or stall
    set_d(1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd0);
    tick();
    set_d(1, 1, 1, 0, 1, 0, 3'd0, 5'd1, 5'd0, 5'd0);
    tick();
    set_d(1, 1, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd12);
    settle();
    check("x0_stalld", StallD, 0);
    check("x0_flushe", FlushE, 0);
    tick();
    check("x0_fwd_a", ForwardAE, 2'b00);
    check("x0_fwd_b", ForwardBE, 2'b00);
    check("x0_stall_cnt", stall_cnt, 1);
    drain();

    // reset asserted mid-stall
    set_d(1, 1, 1, 0, 1, 0, 3'd0, 5'd1, 5'd0, 5'd6);
    tick();
    set_d(1, 1, 0, 0, 0, 0, 3'd0, 5'd6, 5'd0, 5'd9);
    settle();
    check("mid_stall_before", StallD, 1);
    rst_n = 1'b0;
    settle();
    check("mid_rst_stalld", StallD, 0);
    check("mid_rst_flushe", FlushE, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    check("mid_rst_flush_cnt", flush_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_stalld", StallD, 0);
    check("post_rst_stall_cnt", stall_cnt, 0);
    drain();

    // lw x6,0(x6) repeatedly: one stall every two cycles, 2^CNT_W+3 stalls
    set_d(1, 1, 1, 0, 1, 0, 3'd0, 5'd6, 5'd0, 5'd6);
    tick();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      check("sat_stall_active", StallD, 1);
      tick();
      check("sat_stall_cnt", stall_cnt, (i + 1 < (1 << CNT_W) - 1) ? i + 1 : (1 << CNT_W) - 1);
      tick();
    end
    check("sat_final", stall_cnt, (1 << CNT_W) - 1);
    check("sat_flush_cnt", flush_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
